real_gen_fifo_bank: RTL

//  Bank of independent per-channel FIFOs. Channel count and depth come from real

---
 rtl/real_gen_fifo_bank.sv | 107 ++++++++++
 1 files changed

// File: rtl/real_gen_fifo_bank.sv
// Bank of independent per-channel FIFOs. Geometry comes from real parameters
// truncated with $rtoi; a real threshold picks registered-output or show-ahead reads.
module real_gen_fifo_bank #(
  parameter int  WIDTH       = 8,
  parameter real DEPTH_REAL  = 4.0,
  parameter real CHAN_REAL   = 2.5,
  parameter real MODE_THRESH = 3.5,
  localparam int DEPTH    = $rtoi(DEPTH_REAL),
  localparam int CHANNELS = $rtoi(CHAN_REAL),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       wr_en,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  input  logic [CHANNELS-1:0]       rd_en,
  output logic [CHANNELS*WIDTH-1:0] rd_data,
  output logic [CHANNELS-1:0]       rd_valid,
  output logic [CHANNELS-1:0]       full,
  output logic [CHANNELS-1:0]       empty,
  output logic [CHANNELS*CW-1:0]    count,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       underflow
);

  // DEPTH >= 2, so a plain clog2 pointer is never zero-width.
  localparam int PW = $clog2(DEPTH);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             full_q, empty_q, ovf_q, unf_q;
    logic             push, pop;
    logic [WIDTH-1:0] din, dout;
    logic             dvalid;

    assign din  = wr_data[c*WIDTH +: WIDTH];
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign pop  = rd_en[c] & ~empty_q;
    assign push = wr_en[c] & (~full_q | pop);

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
      cnt_nxt = cnt;
      if (push && !pop)      cnt_nxt = cnt + CW'(1);
      else if (pop && !push) cnt_nxt = cnt - CW'(1);
    end

    // Pointers, registered flags and sticky error bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        cnt     <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        // Explicit wrap because DEPTH need not be a power of two.
        if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
        if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
        cnt     <= cnt_nxt;
        full_q  <= (cnt_nxt == CW'(DEPTH));
        empty_q <= (cnt_nxt == '0);
        if (wr_en[c] && !push)   ovf_q <= 1'b1;
        if (rd_en[c] && empty_q) unf_q <= 1'b1;
      end
    end

    // Storage write; contents are never cleared, the pointers make them stale.
    always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= din;
    end

    if (MODE_THRESH > 3.0) begin : reg_out_mode
      logic [WIDTH-1:0] q;
      logic             v;
      // Popped word appears one cycle after rd_en; data holds between pops.
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          v <= pop;
          if (pop) q <= mem[rd_ptr];
        end
      end
      assign dout   = q;
      assign dvalid = v;
    end else begin : show_ahead_mode
      // Head word is always visible; rd_en just acknowledges it.
      assign dout   = empty_q ? '0 : mem[rd_ptr];
      assign dvalid = ~empty_q;
    end

    assign rd_data[c*WIDTH +: WIDTH] = dout;
    assign rd_valid[c]               = dvalid;
    assign full[c]                   = full_q;
    assign empty[c]                  = empty_q;
    assign count[c*CW +: CW]         = cnt;
    assign overflow[c]               = ovf_q;
    assign underflow[c]              = unf_q;
  end

endmodule
